// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: DBIT data bits LSB first, SB_TICK-long stop period,
// one-entry holding register for gapless back-to-back frames. Define UART_TX_PARITY_EN for a parity bit.
module uart_tx_frame #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
`ifdef UART_TX_PARITY_EN
  input  logic            parity_odd,
`endif
  output logic            tx_ready,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int BW = $clog2(DBIT + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DBIT_LAST = BW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e          state_q;
  logic [TW-1:0]   tick_q;
  logic [BW-1:0]   bit_q;
  logic            hold_valid_q;
  logic            tx_q;
  logic            done_q;
  logic [DBIT-1:0] hold_data_q;
  logic [DBIT-1:0] shift_q;
  logic [DBIT-1:0] shift_d;
`ifdef UART_TX_PARITY_EN
  logic            hold_par_q;
  logic            par_q;
`endif

  logic accept;
  logic tick_last;
  logic stop_last;
  logic reload;
  logic bit_adv;

  // A reload needs hold_valid=1 and an accept needs hold_valid=0, so the two never collide.
  always_comb begin
    accept    = tx_start && !hold_valid_q;
    tick_last = s_tick && (tick_q == BIT_LAST);
    stop_last = s_tick && (tick_q == STOP_LAST);
    reload    = hold_valid_q &&
                ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_last));
    bit_adv   = (state_q == S_DATA) && tick_last;
    shift_d   = shift_q;
    if (reload)
      shift_d = hold_data_q;
    else if (bit_adv)
      shift_d = shift_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_q <= din;
`ifdef UART_TX_PARITY_EN
      hold_par_q  <= parity_odd;
`endif
    end
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    if (reload)
      par_q <= (^hold_data_q) ^ hold_par_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (reload)
        hold_valid_q <= 1'b0;
      else if (accept)
        hold_valid_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (hold_valid_q) begin
            state_q <= S_START;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (tick_last) begin
            state_q <= S_DATA;
            tick_q  <= '0;
            tx_q    <= shift_q[0];
          end else if (s_tick) begin
            tick_q  <= tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_last) begin
            tick_q <= '0;
            if (bit_q == DBIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + BW'(1);
              tx_q  <= shift_q[1];
            end
          end else if (s_tick) begin
            tick_q <= tick_q + TW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick_last) begin
            state_q <= S_STOP;
            tick_q  <= '0;
            tx_q    <= 1'b1;
          end else if (s_tick) begin
            tick_q  <= tick_q + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (stop_last) begin
            done_q <= 1'b1;
            tick_q <= '0;
            // A pending word starts its start bit on this very edge: no idle gap.
            if (hold_valid_q) begin
              state_q <= S_START;
              bit_q   <= '0;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else if (s_tick) begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready     = !hold_valid_q;
  assign tx_busy      = (state_q != S_IDLE);
  assign tx_done_tick = done_q;
  assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: default 8-bit instance plus a DBIT=7, 2-stop-bit instance.
// Honours UART_TX_PARITY_EN for the parity frames.
`timescale 1ns/1ps
module tb_uart_tx_frame;
  localparam int DIV = 3;  // clk per s_tick, kept short so frames stay a few hundred clocks
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB8    = 10 + P;
  localparam int NB7    = 10 + P;
  localparam int FRAME8 = (9 + P) * 16 + 16;
  localparam int FRAME7 = (8 + P) * 16 + 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0, tx_start7 = 1'b0;
  logic [7:0] din = 8'h00;
  logic [6:0] din7 = 7'h00;
`ifdef UART_TX_PARITY_EN
  logic       parity_odd = 1'b0;
`endif
  logic tx_ready, tx_busy, tx_done_tick, tx;
  logic tx_ready7, tx_busy7, tx_done_tick7, tx7;
  int   vectors = 0, miscompares = 0, tick_count = 0, divcnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) begin
    divcnt = (divcnt == DIV - 1) ? 0 : divcnt + 1;
    s_tick = (divcnt == 0);
  end
  always @(posedge clk) if (s_tick) tick_count++;

  uart_tx_frame dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  uart_tx_frame #(.DBIT(7), .OVERSAMPLE(16), .SB_TICK(32)) dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start7), .din(din7),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx_ready(tx_ready7), .tx_busy(tx_busy7), .tx_done_tick(tx_done_tick7), .tx(tx7)
  );

  // Line image, bit k = bit-time k (0 = start). Words used here have even popcount, so parity bit is 0 with parity_odd=0.
  function automatic logic [11:0] frame8(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b0, 1'b1, 1'b0, d, 1'b0};
`else
    return {2'b00, 1'b1, d, 1'b0};
`endif
  endfunction

  function automatic logic [11:0] frame7(input logic [6:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b0, 2'b11, 1'b0, d, 1'b0};
`else
    return {2'b00, 2'b11, d, 1'b0};
`endif
  endfunction

  task automatic send(input bit sel, input logic [7:0] v);
    int g = 0;
    @(negedge clk);
    while ((sel ? tx_ready7 : tx_ready) !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    if ((sel ? tx_ready7 : tx_ready) !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL send_ready_timeout tx_ready=%b required=1", sel ? tx_ready7 : tx_ready);
    end
    if (sel) begin din7 = v[6:0]; tx_start7 = 1'b1; end
    else begin din = v; tx_start = 1'b1; end
    @(negedge clk);
    tx_start = 1'b0; tx_start7 = 1'b0;
  endtask

  task automatic wait_start(input bit sel, output int t0);
    int g = 0;
    do begin @(negedge clk); g++; end while ((sel ? tx7 : tx) !== 1'b0 && g < 5000);
    if ((sel ? tx7 : tx) !== 1'b0) begin
      vectors++; miscompares++;
      $display("FAIL start_bit_timeout tx=%b required=0", sel ? tx7 : tx);
    end
    t0 = tick_count;
  endtask

  task automatic wait_tick(input int target);
    int g = 0;
    while (tick_count < target && g < 5000) begin @(negedge clk); g++; end
    if (tick_count < target) begin
      vectors++; miscompares++;
      $display("FAIL tick_wait_timeout ticks=%0d required=%0d", tick_count, target);
    end
  endtask

  task automatic capture(input bit sel, input int t0, input int nb, output logic [11:0] bits);
    bits = '0;
    for (int k = 0; k < nb; k++) begin
      wait_tick(t0 + 16 * k + 8);
      bits[k] = sel ? tx7 : tx;
    end
  endtask

  task automatic wait_done(input bit sel, output int td, output bit ready_seen);
    int g = 0;
    ready_seen = 1'b0;
    while ((sel ? tx_done_tick7 : tx_done_tick) !== 1'b1 && g < 5000) begin
      if ((sel ? tx_ready7 : tx_ready) === 1'b1) ready_seen = 1'b1;
      @(negedge clk); g++;
    end
    if ((sel ? tx_done_tick7 : tx_done_tick) !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout tx_done_tick=%b required=1", sel ? tx_done_tick7 : tx_done_tick);
    end
    td = tick_count;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got=%b exp=1", tx); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    vectors++; if (tx_done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", tx_done_tick); end
    vectors++; if (tx7 !== 1'b1) begin miscompares++; $display("FAIL reset_tx7 got=%b exp=1", tx7); end
  endtask

  task automatic test_8n1;
    logic [11:0] bits; int t0, td; bit rs;
    send(1'b0, 8'h55);
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL ready_after_accept got=%b exp=0", tx_ready); end
    wait_start(1'b0, t0);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_start got=%b exp=1", tx_ready); end
    vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL busy_in_frame got=%b exp=1", tx_busy); end
    capture(1'b0, t0, NB8, bits);
    vectors++; if (bits !== frame8(8'h55)) begin miscompares++; $display("FAIL line_55 got=%h exp=%h", bits, frame8(8'h55)); end
    wait_done(1'b0, td, rs);
    vectors++; if (td - t0 != FRAME8) begin miscompares++; $display("FAIL frame_len_55 got=%0d exp=%0d", td - t0, FRAME8); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_frame got=%b exp=0", tx_busy); end
    @(negedge clk);
    vectors++; if (tx_done_tick !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width got=%b exp=0", tx_done_tick); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] bits; int t0a, t0b, td; bit rs, low_seen;
    send(1'b0, 8'hA5);
    wait_start(1'b0, t0a);
    send(1'b0, 8'h3C);
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_hold_full got=%b exp=0", tx_ready); end
    din = 8'hFF; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    capture(1'b0, t0a, NB8, bits);
    vectors++; if (bits !== frame8(8'hA5)) begin miscompares++; $display("FAIL line_A5 got=%h exp=%h", bits, frame8(8'hA5)); end
    wait_done(1'b0, td, rs);
    vectors++; if (rs !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_early got=%b exp=0", rs); end
    vectors++; if (td - t0a != FRAME8) begin miscompares++; $display("FAIL frame_len_A5 got=%0d exp=%0d", td - t0a, FRAME8); end
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL b2b_no_gap got=%b exp=0", tx); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_reload got=%b exp=1", tx_ready); end
    t0b = td;
    capture(1'b0, t0b, NB8, bits);
    vectors++; if (bits !== frame8(8'h3C)) begin miscompares++; $display("FAIL line_3C got=%h exp=%h", bits, frame8(8'h3C)); end
    wait_done(1'b0, td, rs);
    vectors++; if (td - t0b != FRAME8) begin miscompares++; $display("FAIL frame_len_3C got=%0d exp=%0d", td - t0b, FRAME8); end
    low_seen = 1'b0;
    repeat (40 * DIV) begin @(negedge clk); if (tx !== 1'b1 || tx_busy !== 1'b0) low_seen = 1'b1; end
    vectors++; if (low_seen !== 1'b0) begin miscompares++; $display("FAIL dropped_start_sent got=%b exp=0", low_seen); end
  endtask

  task automatic test_reload_collision;
    logic [11:0] bits; int t0, td; bit rs;
    send(1'b0, 8'h22);
    wait_start(1'b0, t0);
    send(1'b0, 8'h33);
    din = 8'h5A; tx_start = 1'b1;
    wait_done(1'b0, td, rs);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL collide_rejected got=%b exp=1", tx_ready); end
    t0 = td;
    @(negedge clk);
    tx_start = 1'b0;
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL collide_next_accept got=%b exp=0", tx_ready); end
    capture(1'b0, t0, NB8, bits);
    vectors++; if (bits !== frame8(8'h33)) begin miscompares++; $display("FAIL line_33 got=%h exp=%h", bits, frame8(8'h33)); end
    wait_done(1'b0, td, rs);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL collide_no_gap got=%b exp=0", tx); end
    t0 = td;
    capture(1'b0, t0, NB8, bits);
    vectors++; if (bits !== frame8(8'h5A)) begin miscompares++; $display("FAIL line_5A got=%h exp=%h", bits, frame8(8'h5A)); end
    wait_done(1'b0, td, rs);
  endtask

  task automatic test_reset_mid;
    int t0; bit bad;
    send(1'b0, 8'h00);
    wait_start(1'b0, t0);
    send(1'b0, 8'h5A);
    wait_tick(t0 + 16 + 8 + 16);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL mid_data_bit got=%b exp=0", tx); end
    reset = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL async_reset_tx got=%b exp=1", tx); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_busy got=%b exp=0", tx_busy); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset_ready got=%b exp=1", tx_ready); end
    vectors++; if (tx_done_tick !== 1'b0) begin miscompares++; $display("FAIL async_reset_done got=%b exp=0", tx_done_tick); end
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (60 * DIV) begin @(negedge clk); if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1; end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL frame_abandoned got=%b exp=0", bad); end
  endtask

  task automatic test_dbit7;
    logic [11:0] bits; int t0, td; bit rs;
    send(1'b1, 8'h41);
    wait_start(1'b1, t0);
    capture(1'b1, t0, NB7, bits);
    vectors++; if (bits !== frame7(7'h41)) begin miscompares++; $display("FAIL line_d7_41 got=%h exp=%h", bits, frame7(7'h41)); end
    wait_done(1'b1, td, rs);
    vectors++; if (td - t0 != FRAME7) begin miscompares++; $display("FAIL frame_len_d7 got=%0d exp=%0d", td - t0, FRAME7); end
    vectors++; if (tx7 !== 1'b1 || tx_busy7 !== 1'b0) begin
      miscompares++; $display("FAIL d7_idle_after tx=%b busy=%b exp tx=1 busy=0", tx7, tx_busy7);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [11:0] bits; int t0, td; bit rs;
    parity_odd = 1'b0;
    send(1'b0, 8'h07);
    wait_start(1'b0, t0);
    capture(1'b0, t0, 11, bits);
    vectors++; if (bits !== {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}) begin miscompares++; $display("FAIL parity_07_even got=%h exp=%h", bits, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}); end
    wait_done(1'b0, td, rs);
    vectors++; if (td - t0 != 176) begin miscompares++; $display("FAIL parity_len_07_even got=%0d exp=176", td - t0); end
    parity_odd = 1'b1;
    send(1'b0, 8'h07);
    parity_odd = 1'b0;
    wait_start(1'b0, t0);
    capture(1'b0, t0, 11, bits);
    vectors++; if (bits !== {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}) begin miscompares++; $display("FAIL parity_07_odd got=%h exp=%h", bits, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}); end
    wait_done(1'b0, td, rs);
    vectors++; if (td - t0 != 176) begin miscompares++; $display("FAIL parity_len_07_odd got=%0d exp=176", td - t0); end
    parity_odd = 1'b1;
    send(1'b0, 8'h00);
    parity_odd = 1'b0;
    wait_start(1'b0, t0);
    capture(1'b0, t0, 11, bits);
    vectors++; if (bits !== {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}) begin miscompares++; $display("FAIL parity_00_odd got=%h exp=%h", bits, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}); end
    wait_done(1'b0, td, rs);
    vectors++; if (td - t0 != 176) begin miscompares++; $display("FAIL parity_len_00_odd got=%0d exp=176", td - t0); end
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_back_to_back();
    test_reload_collision();
    test_reset_mid();
    test_dbit7();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter; successor to the fixed 8N1 `uart_tx`. Serialises DBIT-wide words with configurable stop-bit length and optional parity. A one-entry holding register allows back-to-back frames with no idle gap. Sits between a host-side producer (FIFO or CPU register) and the pad, paced by the shared `baud_gen` oversampling tick.

## Interface
- DBIT, 8, data bits per frame, legal 5..9, sent LSB first.
- OVERSAMPLE, 16, `s_tick` pulses per bit period, legal 8..32.
- SB_TICK, 16, `s_tick` pulses in the stop period: 16 = 1 stop bit, 24 = 1.5, 32 = 2 at OVERSAMPLE=16. Legal range OVERSAMPLE..2*OVERSAMPLE.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-low reset.
- s_tick, in, 1, one-clk oversampling strobe from `baud_gen`.
- tx_start, in, 1, load request; qualified by tx_ready.
- din, in, DBIT, word to send; sampled on accepted tx_start.
- parity_odd, in, 1, present only with UART_TX_PARITY_EN; 1 = odd, 0 = even; sampled with din.
- tx_ready, out, 1, holding register empty; reset 1.
- tx_busy, out, 1, FSM not in IDLE; reset 0.
- tx_done_tick, out, 1, one-clk pulse at end of each stop period; reset 0.
- tx, out, 1, registered serial line; reset 1 (mark).

## Operation
- Holding register: hold_data, hold_par, hold_valid. When tx_start=1 and tx_ready=1, load din (and parity_odd), set hold_valid. tx_start with tx_ready=0 is ignored; no error flag.
- tx_ready = ~hold_valid.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: tx=1. If hold_valid, go to START: copy hold into shift register, clear hold_valid, zero tick and bit counters.
- START: tx=0. After OVERSAMPLE s_ticks, go to DATA.
- DATA: tx=shift[0]. Every OVERSAMPLE s_ticks, shift right and increment the bit counter. After DBIT bits, go to PARITY if compiled in, else STOP.
- PARITY: tx = XOR of the DBIT data bits XOR parity_odd. Lasts OVERSAMPLE s_ticks, then go to STOP.
- STOP: tx=1 for SB_TICK s_ticks. On the final tick, pulse tx_done_tick. If hold_valid, go straight to START and reload; else go to IDLE.
- Counters:
  - tick counter is $clog2(2*OVERSAMPLE) bits, cleared on every state change;
  - bit counter is $clog2(DBIT+1) bits.
  - Counters advance only on clk edges where s_tick=1.
- Simultaneous events:
  - tx_start accepted in the same clk as the STOP→START reload: the reload empties hold, so tx_ready was already 0 and the start is rejected.
  - tx_start on the clk after the reload is accepted (tx_ready=1 again).
- Reset asserted mid-frame: tx→1, FSM→IDLE, hold_valid→0, tx_done_tick→0, all immediately (asynchronous). The partial frame is abandoned.

## Timing
- Accepted tx_start at edge T: tx_ready=0 after T. At edge T+1 the FSM enters START and tx=0 (registered, after T+1). tx_ready returns to 1 after T+1.
- Each bit lasts exactly OVERSAMPLE s_tick periods, measured from the first s_tick after state entry. Start-bit phase jitter is up to one s_tick period.
- Frame length = (1 + DBIT + P)·OVERSAMPLE + SB_TICK s_ticks, with P=1 when parity is compiled in.
- tx_done_tick coincides with the clk edge that leaves STOP.
- Back-to-back: when hold_valid is set at the end of STOP, the next start bit begins on the following edge with zero idle ticks.
- tx_busy=1 from START entry until IDLE entry.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and parity_odd port exist; one parity bit follows the data bits.
- Undefined: no parity state or port; DATA→STOP directly; frame is start + DBIT + stop.

## Test plan
Clock 100 MHz, baud_gen dvsr=651 (9600 baud, 1 bit = 10416 clk), defaults unless stated.
- Reset: hold reset=0 for 2 clk, release → tx=1, tx_ready=1, tx_busy=0, tx_done_tick=0. Pulse reset=0 mid-DATA → tx=1 within the same cycle, FSM in IDLE.
- 8N1, din=8'h55 → line samples 0,1,0,1,0,1,0,1,0,1; one tx_done_tick about 104160 clk after start; tx_busy low afterwards.
- Back-to-back: send 8'hA5, then while busy send 8'h3C → tx_ready=0 until reload; second start bit begins on the clk after the first tx_done_tick (no idle gap). A third tx_start while tx_ready=0 is dropped.
- DBIT=7, SB_TICK=32, din=7'h41 → 7 data bits 1,0,0,0,0,0,1; stop period 2 bit-times; total 10 bit-times.
- UART_TX_PARITY_EN, din=8'h07:
  - parity_odd=0 → parity bit 1;
  - parity_odd=1 → parity bit 0;
  - frame length 11 bit-times.
- UART_TX_PARITY_EN, din=8'h00, parity_odd=1 → parity bit 1; tx_done_tick after 11 bit-times.
